// File: rtl/csr_file_m.sv
// Machine-mode CSR unit for the single-issue NPC core.
// Implements csrrw/csrrs/csrrc on the M-mode CSRs and the 64-bit mcycle/minstret
// counters. It also owns trap entry (ecall, ebreak, machine-timer interrupt) and
// mret, and drives the fetch redirect. Architectural updates happen only on retire.
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   finish                       current instruction retires this cycle
//   pc, next_pc                  PC of the current instruction / PC after it
//   csr_addr, csr_op, csr_wdata  access request (op: 00 none, 01 RW, 10 RS, 11 RC)
//   csr_rdata, csr_illegal       old CSR value, illegal-access flag (combinational)
//   trap_ecall/ebreak/mret       trap and return requests from the EXU
//   irq_timer                    level machine-timer interrupt
//   redirect_valid, redirect_pc  fetch redirect (combinational)
module csr_file_m #(
    parameter int unsigned XLEN          = 32,
    parameter logic [31:0] MTVEC_RESET   = 32'h8000_0000,
    parameter logic [31:0] MSTATUS_RESET = 32'h0000_1800,
    parameter bit          HAS_COUNTERS  = 1'b1,
    parameter logic [31:0] MVENDORID     = 32'h0,
    parameter logic [31:0] MARCHID       = 32'h0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            finish,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] next_pc,
    input  logic [11:0]     csr_addr,
    input  logic [1:0]      csr_op,
    input  logic [XLEN-1:0] csr_wdata,
    output logic [XLEN-1:0] csr_rdata,
    output logic            csr_illegal,
    input  logic            trap_ecall,
    input  logic            trap_ebreak,
    input  logic            trap_mret,
    input  logic            irq_timer,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc
);
    localparam int unsigned CW = 2 * XLEN;

    localparam logic [11:0] A_MSTATUS   = 12'h300;
    localparam logic [11:0] A_MIE       = 12'h304;
    localparam logic [11:0] A_MTVEC     = 12'h305;
    localparam logic [11:0] A_MSCRATCH  = 12'h340;
    localparam logic [11:0] A_MEPC      = 12'h341;
    localparam logic [11:0] A_MCAUSE    = 12'h342;
    localparam logic [11:0] A_MTVAL     = 12'h343;
    localparam logic [11:0] A_MIP       = 12'h344;
    localparam logic [11:0] A_MCYCLE    = 12'hB00;
    localparam logic [11:0] A_MINSTRET  = 12'hB02;
    localparam logic [11:0] A_MCYCLEH   = 12'hB80;
    localparam logic [11:0] A_MINSTRETH = 12'hB82;
    localparam logic [11:0] A_MVENDORID = 12'hF11;
    localparam logic [11:0] A_MARCHID   = 12'hF12;
    localparam logic [11:0] A_MIMPID    = 12'hF13;
    localparam logic [11:0] A_MHARTID   = 12'hF14;

    localparam logic [1:0] OP_NONE = 2'b00;
    localparam logic [1:0] OP_RW   = 2'b01;
    localparam logic [1:0] OP_RS   = 2'b10;

    // Architectural state; mstatus/mie keep only their implemented bits.
    logic            st_mie;
    logic            st_mpie;
    logic            mie_mtie;
    logic [XLEN-1:0] mtvec;
    logic [XLEN-1:0] mscratch;
    logic [XLEN-1:0] mepc;
    logic [XLEN-1:0] mcause;
    logic [XLEN-1:0] mtval;
    logic [CW-1:0]   mcycle;
    logic [CW-1:0]   minstret;

    logic            implemented;
    logic [XLEN-1:0] old_val;
    logic [XLEN-1:0] new_val;
    logic            wr_req;
    logic            exc_take;
    logic            mret_take;
    logic            irq_take;
    logic            wr_en;
    logic [XLEN-1:0] mtvec_base;

    // Read mux and implemented-address decode.
    always_comb begin
        implemented = 1'b1;
        old_val     = '0;
        case (csr_addr)
            A_MSTATUS: begin
                old_val[12:11] = 2'b11;
                old_val[7]     = st_mpie;
                old_val[3]     = st_mie;
            end
            A_MIE:       old_val[7] = mie_mtie;
            A_MTVEC:     old_val = mtvec;
            A_MSCRATCH:  old_val = mscratch;
            A_MEPC:      old_val = mepc;
            A_MCAUSE:    old_val = mcause;
            A_MTVAL:     old_val = mtval;
            A_MIP:       old_val[7] = irq_timer;
            A_MCYCLE:    old_val = mcycle[XLEN-1:0];
            A_MCYCLEH:   old_val = mcycle[CW-1:XLEN];
            A_MINSTRET:  old_val = minstret[XLEN-1:0];
            A_MINSTRETH: old_val = minstret[CW-1:XLEN];
            A_MVENDORID: old_val = XLEN'(MVENDORID);
            A_MARCHID:   old_val = XLEN'(MARCHID);
            A_MIMPID:    old_val = '0;
            A_MHARTID:   old_val = '0;
            default:     implemented = 1'b0;
        endcase
    end

    // Write value, legality and commit qualification.
    always_comb begin
        case (csr_op)
            OP_RW:   new_val = csr_wdata;
            OP_RS:   new_val = old_val | csr_wdata;
            default: new_val = old_val & ~csr_wdata;
        endcase
        wr_req      = (csr_op == OP_RW) || (csr_wdata != '0);
        csr_illegal = (csr_op != OP_NONE) &&
                      (!implemented || ((csr_addr[11:10] == 2'b11) && wr_req));
        csr_rdata   = (csr_op != OP_NONE) ? old_val : '0;

        exc_take  = finish && (trap_ecall || trap_ebreak);
        mret_take = finish && trap_mret && !exc_take;
        irq_take  = finish && irq_timer && st_mie && mie_mtie &&
                    !trap_ecall && !trap_ebreak && !trap_mret;
        wr_en     = finish && (csr_op != OP_NONE) && !csr_illegal && wr_req &&
                    !exc_take && !mret_take && !irq_take;
    end

    // Redirect target; vectored interrupts land at base + 4*cause.
    always_comb begin
        mtvec_base     = {mtvec[XLEN-1:2], 2'b00};
        redirect_valid = !rst && (exc_take || mret_take || irq_take);
        if (mret_take)
            redirect_pc = mepc;
        else if (irq_take && (mtvec[1:0] == 2'b01))
            redirect_pc = mtvec_base + XLEN'(28);
        else
            redirect_pc = mtvec_base;
    end

    // State update: trap/mret beat CSR writes; counter writes beat increments.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_mie   <= MSTATUS_RESET[3];
            st_mpie  <= MSTATUS_RESET[7];
            mie_mtie <= 1'b0;
            mtvec    <= XLEN'(MTVEC_RESET);
            mscratch <= '0;
            mepc     <= '0;
            mcause   <= '0;
            mtval    <= '0;
            mcycle   <= '0;
            minstret <= '0;
        end else begin
            if (exc_take) begin
                mepc    <= pc;
                mcause  <= trap_ecall ? XLEN'(11) : XLEN'(3);
                mtval   <= trap_ecall ? '0 : pc;
                st_mpie <= st_mie;
                st_mie  <= 1'b0;
            end else if (mret_take) begin
                st_mie  <= st_mpie;
                st_mpie <= 1'b1;
            end else if (irq_take) begin
                mepc    <= next_pc;
                mcause  <= {1'b1, (XLEN-1)'(7)};
                mtval   <= '0;
                st_mpie <= st_mie;
                st_mie  <= 1'b0;
            end else if (wr_en) begin
                case (csr_addr)
                    A_MSTATUS: begin
                        st_mie  <= new_val[3];
                        st_mpie <= new_val[7];
                    end
                    A_MIE:      mie_mtie <= new_val[7];
                    A_MTVEC:    mtvec <= {new_val[XLEN-1:2],
                                          (new_val[1:0] == 2'b01) ? 2'b01 : 2'b00};
                    A_MSCRATCH: mscratch <= new_val;
                    A_MEPC:     mepc <= {new_val[XLEN-1:2], 2'b00};
                    A_MCAUSE:   mcause <= new_val;
                    A_MTVAL:    mtval <= new_val;
                    default: ;
                endcase
            end

            if (!HAS_COUNTERS) begin
                mcycle   <= '0;
                minstret <= '0;
            end else begin
                if (wr_en && (csr_addr == A_MCYCLE))
                    mcycle <= {mcycle[CW-1:XLEN], new_val};
                else if (wr_en && (csr_addr == A_MCYCLEH))
                    mcycle <= {new_val, mcycle[XLEN-1:0]};
                else
                    mcycle <= mcycle + CW'(1);

                if (wr_en && (csr_addr == A_MINSTRET))
                    minstret <= {minstret[CW-1:XLEN], new_val};
                else if (wr_en && (csr_addr == A_MINSTRETH))
                    minstret <= {new_val, minstret[XLEN-1:0]};
                else if (finish)
                    minstret <= minstret + CW'(1);
            end
        end
    end
endmodule

// File: doc/csr_file_m.md
Name: csr_file_m

Overview:
- Parametrised machine-mode CSR unit for the single-issue NPC core; successor to the fixed four-register CSR block.
- Implements csrrw/csrrs/csrrc semantics and the registers mstatus, mie, mtvec, mscratch, mepc, mcause, mtval, mip, 64-bit mcycle/minstret, and read-only ID registers.
- Owns trap entry (ecall, ebreak, timer interrupt) and mret, and drives the PC redirect to the fetch stage.
- Sits beside the EXU; all architectural updates are gated by instruction retire (`finish`).

Parameters:
XLEN, 32, data width of every CSR port and register (32 only; mcycleh/minstreth exist because XLEN=32)
MTVEC_RESET, 32'h8000_0000, reset value of mtvec
MSTATUS_RESET, 32'h0000_1800, reset value of mstatus (MPP=11, MIE=0, MPIE=0)
HAS_COUNTERS, 1, 1 instantiates mcycle/minstret; 0 ties them to 0 and makes them read-only
MVENDORID, 32'h0, constant for 0xF11
MARCHID, 32'h0, constant for 0xF12

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
finish  in  1  current instruction retires this cycle
pc  in  XLEN  PC of the current instruction
next_pc  in  XLEN  PC that would execute after the current instruction
csr_addr  in  12  CSR address
csr_op  in  2  00 none, 01 RW, 10 RS, 11 RC
csr_wdata  in  XLEN  rs1 value or zero-extended immediate
csr_rdata  out  XLEN  old CSR value (goes to rd)
csr_illegal  out  1  access is illegal
trap_ecall  in  1  current instruction is ecall
trap_ebreak  in  1  current instruction is ebreak
trap_mret  in  1  current instruction is mret
irq_timer  in  1  level machine-timer interrupt request
redirect_valid  out  1  fetch must jump to redirect_pc
redirect_pc  out  XLEN  trap vector or mepc

Behaviour:
- Reset (async, rst=1):
  - mstatus=MSTATUS_RESET; mtvec=MTVEC_RESET.
  - mie, mscratch, mepc, mcause, mtval, mcycle, minstret all = 0.
  - Outputs are combinational; during reset they reflect these reset values.
- Read path (combinational):
  - csr_rdata = selected register when csr_op!=00, else 0.
  - mip reads {24'b0, irq_timer, 7'b0}, i.e. MTIP is bit 7.
  - mstatus reads with only MIE (bit 3), MPIE (bit 7) and MPP (bits 12:11, hard-wired 11) non-zero.
- Write value:
  - RW: new = wdata.
  - RS: new = old | wdata.
  - RC: new = old & ~wdata.
  - RS/RC with wdata==0 perform no write.
- Write commit:
  - Commits at posedge when finish=1, csr_op!=00, csr_illegal=0, and no trap/mret is taken.
  - Write masks: mtvec bits[1:0] keep only values 00/01 (any value ≥2 stores 00); mepc bit[1:0] forced 0; mie keeps bit 7 only; mip is read-only.
- csr_illegal=1 in either case:
  - Unimplemented address.
  - Writing access (RW, or RS/RC with wdata!=0) to a read-only address (addr[11:10]==11).
  - The EXU turns this into an illegal-instruction trap; this block only suppresses the write.
- Counters:
  - mcycle (0xB00/0xB80) increments every cycle, including cycles without finish.
  - minstret (0xB02/0xB82) increments at each posedge where finish=1.
  - Carry from the low to the high word happens in the same cycle.
  - A CSR write to either half takes priority over that cycle's increment for the whole 64-bit counter; the other half keeps its pre-increment value.
  - Wrap from 2^64-1 to 0 is silent.
- Trap priority (evaluated only when finish=1): ecall/ebreak > mret > timer interrupt > CSR write.
- Interrupt taken iff irq_timer & mstatus.MIE & mie[7] & finish & no ecall/ebreak/mret.
- Trap entry (at posedge):
  - mepc: pc for exceptions, next_pc for interrupt.
  - mcause: 11 for ecall, 3 for ebreak, 32'h8000_0007 for interrupt.
  - mtval: 0 for ecall/interrupt, pc for ebreak.
  - MPIE<=MIE, MIE<=0.
- mret (at posedge): MIE<=MPIE, MPIE<=1.
- Redirect (combinational, same cycle as the qualifying finish):
  - redirect_valid=1 for a taken trap or mret.
  - redirect_pc = {mtvec[31:2],2'b00} for exceptions and direct mode.
  - In vectored mode (mtvec[1:0]=01), interrupt redirect_pc = base + 4*7.
  - mret redirect_pc = current mepc.
- Without finish:
  - No architectural state changes except mcycle.
  - redirect_valid=0.
- Reset asserted mid-trap: state returns to reset values immediately; redirect_valid drops to 0.

Test Plan:
- Reset, then read 0x300, 0x305, 0xB00 → 0x1800, 0x8000_0000, then mcycle equal to cycles since reset release.
- csrrw 0x305, wdata 0x8000_0101 → mtvec reads 0x8000_0101. Then csrrc 0x305, wdata 0x1 → mtvec reads 0x8000_0100.
- ecall at pc=0x8000_0010 with finish → redirect_valid=1, redirect_pc=0x8000_0100. Next cycle: mepc=0x8000_0010, mcause=11, MIE=0. Then mret → redirect_pc=0x8000_0010.
- Set mie=0x80, mstatus.MIE=1, mtvec=0x8000_0001, raise irq_timer, finish with next_pc=0x8000_0044 → redirect_pc=0x8000_001C, mepc=0x8000_0044, mcause=0x8000_0007.
- csrrw to 0xF11 → csr_illegal=1, value unchanged. csrrs to 0xF11 with wdata=0 → csr_illegal=0, reads MVENDORID.
- Write mcycle low=0xFFFF_FFFF, high=0 → after 1 cycle mcycleh=1, mcycle=0. Assert rst mid-ecall → all registers return to reset values.
